// File: rtl/data_mem_bytelane.sv
// Big-endian byte-addressable data memory with valid/ready request/response handshake,
// byte/halfword/word accesses, load extension, error reporting and a post-reset clear sweep.
module data_mem_bytelane #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int BPW     = DATA_W / 8;
    localparam int WORDS   = DEPTH_BYTES / BPW;
    localparam int LOG_BPW = $clog2(BPW);
    localparam int WAW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SH_W    = $clog2(DATA_W) + 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WAW-1:0]   clr_cnt_q, clr_cnt_d;
    logic             clr_en;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_load_q, rsp_load_d;
    logic [1:0]       rsp_size_q, rsp_size_d;
    logic             rsp_signed_q, rsp_signed_d;
    logic [SH_W-1:0]  rsp_shamt_q, rsp_shamt_d;

    logic [2:0]         size_bytes;
    logic               size_err;
    logic               align_err;
    logic               range_err;
    logic               req_err;
    logic               accept;
    logic               store_fire;
    logic               load_fire;
    logic [LOG_BPW-1:0] lane_off;
    logic [WAW-1:0]     word_idx;
    logic [SH_W-1:0]    shamt;
    logic [DATA_W-1:0]  wr_aligned;
    logic [DATA_W-1:0] rd_word;

    // ------------------------------------------------------------------
    // INIT/RUN control: INIT zeroes one word per cycle, then hands over.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_en    = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_en = 1'b1;
                if (clr_cnt_q == WAW'(WORDS - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign req_ready_o = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    // ------------------------------------------------------------------
    // Request decode and error checks
    // ------------------------------------------------------------------
    always_comb begin
        case (req_size_i)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    end

    assign size_err  = (req_size_i == 2'd3) || (32'(size_bytes) > BPW);
    assign align_err = (req_addr_i[2:0] & (size_bytes - 3'd1)) != 3'd0;
    // One extra bit so an access running past the top cannot wrap into range.
    assign range_err = ({1'b0, req_addr_i} + (ADDR_W+1)'(size_bytes))
                       > (ADDR_W+1)'(DEPTH_BYTES);
    assign req_err   = size_err || align_err || range_err;

    assign store_fire = accept && req_we_i && !req_err;
    assign load_fire  = accept && !req_we_i && !req_err;

    assign lane_off = req_addr_i[LOG_BPW-1:0];
    assign word_idx = req_addr_i[LOG_BPW +: WAW];

    // Lane 0 is the most significant byte of a word; the shift moves an access
    // between the LSBs of the data bus and its big-endian lane position.
    assign shamt      = SH_W'(8 * (BPW - 32'(size_bytes) - 32'(lane_off)));
    assign wr_aligned = req_wdata_i << shamt;

    // ------------------------------------------------------------------
    // Byte-lane storage: one array per lane with registered read
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
        logic [7:0]     mem [WORDS];
        logic [7:0]     rd_q;
        logic           lane_hit;
        logic           lane_we;
        logic [WAW-1:0] wr_addr;
        logic [7:0]     wr_byte;

        assign lane_hit = (32'(lane_off) <= gi) && (gi < 32'(lane_off) + 32'(size_bytes));
        assign lane_we  = clr_en || (store_fire && lane_hit);
        assign wr_addr  = clr_en ? clr_cnt_q : word_idx;
        assign wr_byte  = clr_en ? 8'h00 : wr_aligned[DATA_W-1-8*gi -: 8];

        always_ff @(posedge clk) begin
            if (lane_we) begin
                mem[wr_addr] <= wr_byte;
            end
            if (load_fire) begin
                rd_q <= mem[word_idx];
            end
        end

        assign rd_word[DATA_W-1-8*gi -: 8] = rd_q;
    end

    // ------------------------------------------------------------------
    // Response stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_load_q   <= 1'b0;
            rsp_size_q   <= 2'd0;
            rsp_signed_q <= 1'b0;
            rsp_shamt_q  <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_load_q   <= rsp_load_d;
            rsp_size_q   <= rsp_size_d;
            rsp_signed_q <= rsp_signed_d;
            rsp_shamt_q  <= rsp_shamt_d;
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_load_d   = rsp_load_q;
        rsp_size_d   = rsp_size_q;
        rsp_signed_d = rsp_signed_q;
        rsp_shamt_d  = rsp_shamt_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_err_d    = req_err;
            rsp_load_d   = load_fire;
            rsp_size_d   = req_size_i;
            rsp_signed_d = req_signed_i;
            rsp_shamt_d  = shamt;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_load_d  = 1'b0;
        end
    end

    // Extraction works off the held read word, so the data stays stable under back-pressure.
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] rd_mask;
    logic              rd_sign;
    logic [DATA_W-1:0] rd_fill;
    logic [DATA_W-1:0] rd_ext;

    always_comb begin
        rd_shifted = rd_word >> rsp_shamt_q;
        case (rsp_size_q)
            2'd0: begin
                rd_mask = DATA_W'(8'hFF);
                rd_sign = rd_shifted[7];
            end
            2'd1: begin
                rd_mask = DATA_W'(16'hFFFF);
                rd_sign = rd_shifted[15];
            end
            default: begin
                rd_mask = '1;
                rd_sign = 1'b0;
            end
        endcase
        rd_fill = rsp_signed_q ? {DATA_W{rd_sign}} : '0;
        rd_ext  = (rd_shifted & rd_mask) | (rd_fill & ~rd_mask);
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_load_q ? rd_ext : '0;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed testbench for data_mem_bytelane at its default parameters (16-bit data, 64 bytes).
module tb_data_mem_bytelane;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    int n_pass;
    int n_total;

    data_mem_bytelane #(
        .DATA_W(16),
        .DEPTH_BYTES(64),
        .ADDR_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i(req_we),
        .req_size_i(req_size),
        .req_signed_i(req_signed),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single request with rsp_ready held high; returns the response seen one cycle after accept.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [15:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output logic er, output logic ok);
        int waited;
        @(negedge clk);
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        waited     = 0;
        #1;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            rd = 16'h0;
            er = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            ok = rsp_valid;
            rd = rsp_rdata;
            er = rsp_err;
        end
    endtask

    // Release reset at a negedge and count rising edges until req_ready is seen high.
    task automatic count_init(output int cnt);
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        while (!req_ready && cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        logic er, ok;
        int cnt;
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b exp 0", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 16'h0) $display("FAIL reset_rsp_rdata: got %h exp 0000", rsp_rdata); else n_pass++;
        n_total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); else n_pass++;
        repeat (3) @(posedge clk);
        count_init(cnt);
        $display("init: req_ready rose after %0d cycles", cnt);
        n_total++; if (cnt !== 32) $display("FAIL init_cycles: got %0d exp 32", cnt); else n_pass++;
        do_req(1'b0, 2'd1, 1'b0, 16'h003E, 16'h0, rd, er, ok);
        $display("load h @3E -> %h err=%b valid=%b", rd, er, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL clear_load_valid: got %b exp 1", ok); else n_pass++;
        n_total++; if (rd !== 16'h0000) $display("FAIL clear_load_data: got %h exp 0000", rd); else n_pass++;
        n_total++; if (er !== 1'b0) $display("FAIL clear_load_err: got %b exp 0", er); else n_pass++;
    endtask

    task automatic test_endian;
        logic [15:0] rd;
        logic er, ok;
        do_req(1'b1, 2'd1, 1'b0, 16'h0010, 16'hA1B2, rd, er, ok);
        $display("store h A1B2 @10 -> %h err=%b", rd, er);
        n_total++; if (ok !== 1'b1 || er !== 1'b0 || rd !== 16'h0) $display("FAIL store_rsp: got valid=%b err=%b data=%h exp 1/0/0000", ok, er, rd); else n_pass++;
        do_req(1'b0, 2'd0, 1'b0, 16'h0010, 16'h0, rd, er, ok);
        $display("load b @10 -> %h err=%b", rd, er);
        n_total++; if (rd !== 16'h00A1 || er !== 1'b0) $display("FAIL endian_byte10: got %h err=%b exp 00A1 err=0", rd, er); else n_pass++;
        do_req(1'b0, 2'd0, 1'b0, 16'h0011, 16'h0, rd, er, ok);
        $display("load b @11 -> %h err=%b", rd, er);
        n_total++; if (rd !== 16'h00B2 || er !== 1'b0) $display("FAIL endian_byte11: got %h err=%b exp 00B2 err=0", rd, er); else n_pass++;
        do_req(1'b0, 2'd1, 1'b0, 16'h0010, 16'h0, rd, er, ok);
        $display("load h @10 -> %h err=%b", rd, er);
        n_total++; if (rd !== 16'hA1B2 || er !== 1'b0) $display("FAIL endian_half10: got %h err=%b exp A1B2 err=0", rd, er); else n_pass++;
        do_req(1'b0, 2'd1, 1'b1, 16'h0010, 16'h0, rd, er, ok);
        $display("load h signed @10 -> %h err=%b", rd, er);
        n_total++; if (rd !== 16'hA1B2) $display("FAIL fullwidth_signed: got %h exp A1B2", rd); else n_pass++;
    endtask

    task automatic test_sign_ext;
        logic [15:0] rd;
        logic er, ok;
        do_req(1'b1, 2'd0, 1'b0, 16'h0005, 16'h1280, rd, er, ok);
        $display("store b 80 @05 -> err=%b", er);
        do_req(1'b0, 2'd0, 1'b1, 16'h0005, 16'h0, rd, er, ok);
        $display("load b signed @05 -> %h", rd);
        n_total++; if (rd !== 16'hFF80) $display("FAIL sext_byte: got %h exp FF80", rd); else n_pass++;
        do_req(1'b0, 2'd0, 1'b0, 16'h0005, 16'h0, rd, er, ok);
        $display("load b unsigned @05 -> %h", rd);
        n_total++; if (rd !== 16'h0080) $display("FAIL zext_byte: got %h exp 0080", rd); else n_pass++;
        do_req(1'b0, 2'd1, 1'b1, 16'h0004, 16'h0, rd, er, ok);
        $display("load h signed @04 -> %h", rd);
        n_total++; if (rd !== 16'h0080) $display("FAIL neighbour_half: got %h exp 0080", rd); else n_pass++;
    endtask

    task automatic test_errors;
        logic [15:0] rd;
        logic er, ok;
        logic        e_we [5];
        logic [1:0]  e_sz [5];
        logic [15:0] e_ad [5];
        e_we = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        e_sz = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
        e_ad = '{16'h0011, 16'h003F, 16'h0040, 16'h0000, 16'h0010};
        for (int i = 0; i < 5; i++) begin
            do_req(e_we[i], e_sz[i], 1'b1, e_ad[i], 16'hDEAD, rd, er, ok);
            $display("err case %0d we=%b size=%0d addr=%h -> err=%b data=%h", i, e_we[i], e_sz[i], e_ad[i], er, rd);
            n_total++; if (ok !== 1'b1 || er !== 1'b1 || rd !== 16'h0) $display("FAIL err_case%0d: got valid=%b err=%b data=%h exp 1/1/0000", i, ok, er, rd); else n_pass++;
        end
        do_req(1'b0, 2'd1, 1'b0, 16'h0010, 16'h0, rd, er, ok);
        $display("load h @10 after errors -> %h err=%b", rd, er);
        n_total++; if (rd !== 16'hA1B2 || er !== 1'b0) $display("FAIL err_no_write: got %h err=%b exp A1B2 err=0", rd, er); else n_pass++;
        do_req(1'b0, 2'd0, 1'b0, 16'h003F, 16'h0, rd, er, ok);
        $display("load b @3F -> %h err=%b", rd, er);
        n_total++; if (rd !== 16'h0000 || er !== 1'b0) $display("FAIL top_byte_legal: got %h err=%b exp 0000 err=0", rd, er); else n_pass++;
    endtask

    // Four halfword loads from base..base+6; the first response is stalled for stall_cycles.
    task automatic test_back_to_back(input int stall_cycles, input logic [15:0] base);
        logic [15:0] rd;
        logic er, ok;
        logic [15:0] expv [4];
        int idx, nresp, stall_left, stall_seen, first_acc, last_acc, first_rsp, last_rsp;
        expv = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 2'd1, 1'b0, base + 16'(2 * i), expv[i], rd, er, ok);
        end
        idx = 0; nresp = 0; stall_left = stall_cycles; stall_seen = 0;
        first_acc = -1; last_acc = -1; first_rsp = -1; last_rsp = -1;
        @(negedge clk);
        for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
            rsp_ready  = 1'b1;
            req_we     = 1'b0;
            req_size   = 2'd1;
            req_signed = 1'b0;
            req_valid  = (idx < 4);
            req_addr   = base + 16'(2 * idx);
            if (rsp_valid && nresp == 0 && stall_left > 0) begin
                rsp_ready = 1'b0;
                stall_left--;
                stall_seen++;
            end
            #1;
            if (!rsp_ready) begin
                n_total++; if (rsp_rdata !== expv[0] || rsp_err !== 1'b0) $display("FAIL stall_hold: got %h err=%b exp %h err=0", rsp_rdata, rsp_err, expv[0]); else n_pass++;
                n_total++; if (req_ready !== 1'b0) $display("FAIL stall_ready: got %b exp 0", req_ready); else n_pass++;
            end
            if (rsp_valid && rsp_ready) begin
                $display("burst rsp %0d cyc %0d -> %h err=%b", nresp, cyc, rsp_rdata, rsp_err);
                n_total++; if (rsp_rdata !== expv[nresp] || rsp_err !== 1'b0) $display("FAIL burst_rsp%0d: got %h err=%b exp %h err=0", nresp, rsp_rdata, rsp_err, expv[nresp]); else n_pass++;
                if (first_rsp < 0) first_rsp = cyc;
                last_rsp = cyc;
                nresp++;
            end
            if (req_valid && req_ready) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                idx++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        $display("burst stall=%0d: accepts=%0d responses=%0d acc %0d..%0d rsp %0d..%0d", stall_cycles, idx, nresp, first_acc, last_acc, first_rsp, last_rsp);
        n_total++; if (nresp !== 4 || idx !== 4) $display("FAIL burst_count: got acc=%0d rsp=%0d exp 4/4", idx, nresp); else n_pass++;
        n_total++; if (stall_seen !== stall_cycles) $display("FAIL burst_stall_len: got %0d exp %0d", stall_seen, stall_cycles); else n_pass++;
        if (stall_cycles == 0) begin
            n_total++; if (last_acc - first_acc !== 3) $display("FAIL throughput_acc: got span %0d exp 3", last_acc - first_acc); else n_pass++;
            n_total++; if (last_rsp - first_rsp !== 3) $display("FAIL throughput_rsp: got span %0d exp 3", last_rsp - first_rsp); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd;
        logic er, ok;
        int cnt;
        @(negedge clk);
        req_we     = 1'b1;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_addr   = 16'h0020;
        req_wdata  = 16'h1234;
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL mid_ready_before: got %b exp 1", req_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        $display("store h 1234 @20 -> valid=%b err=%b", rsp_valid, rsp_err);
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("FAIL mid_store_rsp: got valid=%b err=%b exp 1/0", rsp_valid, rsp_err); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset -> valid=%b ready=%b data=%h err=%b", rsp_valid, req_ready, rsp_rdata, rsp_err);
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid_async_valid: got %b exp 0", rsp_valid); else n_pass++;
        n_total++; if (req_ready !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0) $display("FAIL mid_async_outs: got ready=%b err=%b data=%h exp 0/0/0000", req_ready, rsp_err, rsp_rdata); else n_pass++;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        count_init(cnt);
        $display("re-init: req_ready rose after %0d cycles", cnt);
        n_total++; if (cnt !== 32) $display("FAIL mid_init_cycles: got %0d exp 32", cnt); else n_pass++;
        do_req(1'b0, 2'd1, 1'b0, 16'h0020, 16'h0, rd, er, ok);
        $display("load h @20 after reset -> %h err=%b", rd, er);
        n_total++; if (ok !== 1'b1 || rd !== 16'h0000 || er !== 1'b0) $display("FAIL mid_cleared: got valid=%b data=%h err=%b exp 1/0000/0", ok, rd, er); else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 16'h0;
        req_wdata  = 16'h0;
        rsp_ready  = 1'b1;
        test_reset();
        test_endian();
        test_sign_ext();
        test_errors();
        test_back_to_back(3, 16'h0030);
        test_back_to_back(0, 16'h0038);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
